// File: rtl/decoder_2_4_seq.sv
// decoder_2_4_seq: sequenced 2-to-4 one-hot pulse decoder (PULSE_LEN on, GAP_LEN off); define DEC24_ACTIVE_LOW_EN for inverted out
module decoder_2_4_seq #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       in_valid,
  input  logic [1:0] in_code,
  output logic       in_ready,
  output logic [0:3] out,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;
`ifdef DEC24_ACTIVE_LOW_EN
  localparam logic [0:3] OUT_OFF = 4'b1111;
`else
  localparam logic [0:3] OUT_OFF = 4'b0000;
`endif
  localparam logic [7:0] P_LAST = 8'(PULSE_LEN - 1);
  localparam logic [7:0] G_LAST = (GAP_LEN > 0) ? 8'(GAP_LEN - 1) : 8'd0;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] code_q, code_d;
  logic [0:3] out_q, out_d;
  logic       done_q, done_d;
  assign in_ready = (state_q == IDLE) && en;
  assign busy     = (state_q != IDLE);
  assign out      = out_q;
  assign done     = done_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (en && in_valid) begin
        state_d = ACTIVE;
        cnt_d   = P_LAST;
        code_d  = in_code;
      end
      ACTIVE: if (!en) begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end else if (cnt_q == 8'd0) begin
        state_d = (GAP_LEN > 0) ? GAP : IDLE;
        cnt_d   = G_LAST;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
      GAP: if (!en || cnt_q == 8'd0) begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    out_d = (state_d == ACTIVE) ? ((4'b1000 >> code_d) ^ OUT_OFF) : OUT_OFF;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      code_q  <= 2'b00;
      out_q   <= OUT_OFF;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_decoder_2_4_seq.sv
// tb_decoder_2_4_seq: table, directed and random checks of two decoder_2_4_seq instances against an elapsed-time model
module tb_decoder_2_4_seq;
`ifdef DEC24_ACTIVE_LOW_EN
  localparam logic [3:0] OFF = 4'b1111;
`else
  localparam logic [3:0] OFF = 4'b0000;
`endif
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, in_valid = 1'b0;
  logic [1:0] in_code = 2'b00;
  logic rdy0, busy0, done0, rdy1, busy1, done1;
  logic [0:3] out0, out1;
  int tests = 0, fails = 0;
  bit bm[2], dm[2];
  int age[2], pl[2], gl[2];
  logic [1:0] cm[2];
  typedef struct { logic e, v; logic [1:0] c; logic [3:0] o; logic b, d, r; } vec_t;
  vec_t tbl[12];
  always #5 clk = ~clk;
  decoder_2_4_seq dut (.clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_code(in_code),
    .in_ready(rdy0), .out(out0), .busy(busy0), .done(done0));
  decoder_2_4_seq #(.PULSE_LEN(1), .GAP_LEN(0)) dut1 (.clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .in_code(in_code), .in_ready(rdy1), .out(out1), .busy(busy1), .done(done1));
  task automatic chk(string n, logic [3:0] got, logic [3:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", n, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      bm[i] = 0;
      dm[i] = 0;
      age[i] = 0;
      cm[i] = 2'b00;
    end
  endtask
  task automatic model_edge(int i);
    bit nd = 0;
    if (bm[i]) begin
      if (!en) bm[i] = 0;
      else begin
        if (age[i] == pl[i]) nd = 1;
        age[i]++;
        if (age[i] > pl[i] + gl[i]) bm[i] = 0;
      end
    end else if (en && in_valid) begin
      bm[i] = 1;
      age[i] = 1;
      cm[i] = in_code;
    end
    dm[i] = nd;
  endtask
  task automatic check_models();
    for (int i = 0; i < 2; i++) begin
      logic [3:0] eo;
      eo = (bm[i] && age[i] <= pl[i]) ? ((4'b1000 >> cm[i]) ^ OFF) : OFF;
      chk(i == 0 ? "m0_out" : "m1_out", i == 0 ? out0 : out1, eo);
      chk(i == 0 ? "m0_busy" : "m1_busy", i == 0 ? busy0 : busy1, 4'(bm[i]));
      chk(i == 0 ? "m0_done" : "m1_done", i == 0 ? done0 : done1, 4'(dm[i]));
      chk(i == 0 ? "m0_ready" : "m1_ready", i == 0 ? rdy0 : rdy1, 4'(!bm[i] && en));
    end
  endtask
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      model_edge(0);
      model_edge(1);
    end
    #1;
    check_models();
  endtask
  initial begin
    pl[0] = 4; gl[0] = 1; pl[1] = 1; gl[1] = 0;
    model_reset();
    tbl[0]  = '{1, 1, 2'b10, 4'b0010, 1, 0, 0};
    tbl[1]  = '{1, 0, 2'b10, 4'b0010, 1, 0, 0};
    tbl[2]  = '{1, 0, 2'b00, 4'b0010, 1, 0, 0};
    tbl[3]  = '{1, 0, 2'b00, 4'b0010, 1, 0, 0};
    tbl[4]  = '{1, 0, 2'b00, 4'b0000, 1, 1, 0};
    tbl[5]  = '{1, 0, 2'b00, 4'b0000, 0, 0, 1};
    tbl[6]  = '{0, 1, 2'b11, 4'b0000, 0, 0, 0};
    tbl[7]  = '{1, 1, 2'b01, 4'b0100, 1, 0, 0};
    tbl[8]  = '{1, 1, 2'b11, 4'b0100, 1, 0, 0};
    tbl[9]  = '{0, 0, 2'b11, 4'b0000, 0, 0, 0};
    tbl[10] = '{1, 0, 2'b11, 4'b0000, 0, 0, 1};
    tbl[11] = '{1, 1, 2'b00, 4'b1000, 1, 0, 0};
    #12;
    chk("rst_out", out0, OFF);
    chk("rst_busy", busy0, 4'd0);
    chk("rst_done", done0, 4'd0);
    chk("rst_out1", out1, OFF);
    rst = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      en = tbl[i].e; in_valid = tbl[i].v; in_code = tbl[i].c;
      step();
      chk($sformatf("tbl%0d_out", i), out0, tbl[i].o ^ OFF);
      chk($sformatf("tbl%0d_busy", i), busy0, 4'(tbl[i].b));
      chk($sformatf("tbl%0d_done", i), done0, 4'(tbl[i].d));
      chk($sformatf("tbl%0d_ready", i), rdy0, 4'(tbl[i].r));
    end
    en = 1'b1; in_valid = 1'b0;
    repeat (6) step();
    in_valid = 1'b1; in_code = 2'b11;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("alt%0d_out1", k), out1, ((k % 2 == 0) ? 4'b0001 : 4'b0000) ^ OFF);
      chk($sformatf("alt%0d_done1", k), done1, 4'(k % 2));
    end
    for (int k = 0; k < 40; k++) begin
      in_code = 2'(k / 10);
      step();
    end
    repeat (600) begin
      en = ($urandom % 10) != 0;
      in_valid = ($urandom % 3) != 0;
      in_code = 2'($urandom % 4);
      step();
    end
    en = 1'b0; step();
    en = 1'b1; in_valid = 1'b1; in_code = 2'b11; step();
    in_valid = 1'b0; step();
    #3 rst = 1'b1;
    #1;
    chk("arst_out", out0, OFF);
    chk("arst_busy", busy0, 4'd0);
    chk("arst_done", done0, 4'd0);
    chk("arst_out1", out1, OFF);
    model_reset();
    step();
    rst = 1'b0;
    in_valid = 1'b1; in_code = 2'b01;
    step();
    chk("post_rst_out", out0, 4'b0100 ^ OFF);
    in_valid = 1'b0;
    repeat (6) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/decoder_2_4_seq.md
DECODER_2_4_SEQ -- requirements
Module: decoder_2_4_seq

Interface
REQ-001 Parameter PULSE_LEN, default 4, sets the number of cycles a decoded line stays asserted; legal range 1..255.
REQ-002 Parameter GAP_LEN, default 1, sets the number of forced all-zero cycles after each pulse; legal range 0..255.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port en, input, 1 bit: block enable; 0 blocks acceptance and aborts any pulse in progress.
REQ-006 Port in_valid, input, 1 bit: in_code is valid this cycle.
REQ-007 Port in_code, input, 2 bits [1:0]: binary code to decode.
REQ-008 Port in_ready, output, 1 bit: block accepts a code this cycle.
REQ-009 Port out, output, 4 bits [0:3]: registered one-hot decoded lines; code 00->1000, 01->0100, 10->0010, 11->0001.
REQ-010 Port busy, output, 1 bit: high while in ACTIVE or GAP.
REQ-011 Port done, output, 1 bit: single-cycle pulse marking normal completion of a pulse.

Function
REQ-012 FSM states are IDLE, ACTIVE and GAP, and the FSM has no other reachable states.
REQ-013 in_ready is combinational: 1 only when state=IDLE and en=1.
REQ-014 Acceptance: in_valid=1 and in_ready=1 at an edge; in_code is captured, and the FSM goes to ACTIVE with the counter loaded to PULSE_LEN-1.
REQ-015 out shows the one-hot pattern for the captured code starting in the cycle after acceptance (latency 1), and holds it for exactly PULSE_LEN cycles.
REQ-016 In ACTIVE, the counter decrements each cycle; at counter=0, the FSM goes to GAP (counter=GAP_LEN-1) if GAP_LEN>0, otherwise to IDLE.
REQ-017 out is 0000 in IDLE and GAP, and only ACTIVE drives a nonzero pattern.
REQ-018 out has at most one bit set in every cycle.
REQ-019 done is 1 for exactly one cycle: the first cycle after the last ACTIVE cycle of a pulse that completed normally.
REQ-020 In GAP, the counter decrements each cycle; at counter=0, the FSM goes to IDLE.
REQ-021 in_valid while not ready is ignored, with no queuing; in_code changes outside acceptance do not affect out.
REQ-022 Back-to-back: at least one IDLE cycle (out=0000) separates consecutive pulses even with GAP_LEN=0.
REQ-023 Abort: en=0 in ACTIVE or GAP forces state IDLE, out=0000 and counter=0 at the next edge, and no done pulse is produced.
REQ-024 en=0 in IDLE holds IDLE; in_valid is ignored.
REQ-025 The counter is 8 bits unsigned, and no wrap-around occurs within the legal parameter range.

Reset
REQ-026 rst=1 asynchronously forces state=IDLE, counter=0, captured code=00, out=0000, done=0 and busy=0, including during ACTIVE or GAP.
REQ-027 After rst falls, the first acceptance is possible at the first rising edge with en=1 and in_valid=1.

Configuration
REQ-028 Macro DEC24_ACTIVE_LOW_EN: when defined, out is the bitwise inverse of the REQ-009/REQ-017 values (idle 1111, code 01 -> 1011), including reset value 1111.
REQ-029 Without DEC24_ACTIVE_LOW_EN, out is active-high as in REQ-009, with reset value 0000; all other behaviour is identical in both builds.

Verification
REQ-030 Defaults, en=1, in_code=10, in_valid=1 for one cycle -> out=0010 for 4 cycles starting 1 cycle later, then done=1 for 1 cycle, out=0000, busy low after 1 GAP cycle.
REQ-031 All four codes in sequence, with in_valid held high -> out 1000, 0100, 0010, 0001, each 4 cycles long, each separated by GAP plus IDLE zero cycles; in_ready=0 throughout ACTIVE and GAP.
REQ-032 PULSE_LEN=1, GAP_LEN=0, continuous in_valid with code 11 -> out alternates 0001 and 0000 every cycle; done fires after each 0001.
REQ-033 en dropped in the 2nd ACTIVE cycle of code 01 -> out=0000 at the next edge; no done pulse; the next acceptance occurs after en returns to 1.
REQ-034 rst asserted mid-ACTIVE, asynchronously between edges -> out=0000 and busy=0 immediately; no done pulse; normal operation resumes after release.
REQ-035 DEC24_ACTIVE_LOW_EN defined, code 00 -> out=1111 when idle, 0111 for PULSE_LEN cycles, and 1111 after reset.
